mem_bus_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester (read-only, word) and the data requester (load/store, word/half/byte).
- Sits between the pipeline's IF/MEM stages and the external memory bus; the external side uses the same active-low ACK handshake and SIZE encoding as the existing top-level bus.
- Also keeps grant statistics and a bus-timeout watchdog for the bench.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM states,
// bus SIZE encodings and the default watchdog limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } arb_state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam int unsigned DEF_TIMEOUT = 1024;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones, with a
// synchronous clear below the active-low reset.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and data requesters onto one memory port, with data
// priority from IDLE and forced alternation on back-to-back grants.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNTW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack_n,
    input  logic            d_req,
    input  logic            d_write,
    input  logic [1:0]      d_size,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack_n,
    output logic            m_req,
    output logic            m_write,
    output logic [1:0]      m_size,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack_n,
    output logic            bus_err,
    output logic [CNTW-1:0] i_grant_cnt,
    output logic [CNTW-1:0] d_grant_cnt
);

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    arb_state_t state, state_nxt;
    logic       acked;
    logic       ld_fetch, ld_data;
    logic       i_done, d_done;
    logic       wd_inc, wd_clr;
    logic [WDW-1:0] wd_cnt;

    assign acked  = (state != IDLE) && !m_ack_n;
    assign i_done = (state == IBUSY) && !m_ack_n;
    assign d_done = (state == DBUSY) && !m_ack_n;

    assign m_req  = (state != IDLE);
    assign wd_inc = m_req && m_ack_n;
    assign wd_clr = !m_req || !m_ack_n;

    // Acks are gated by reset so an abandoned transaction never completes.
    assign i_ack_n = !(rst && i_done);
    assign d_ack_n = !(rst && d_done);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_fetch  = 1'b0;
        ld_data   = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req)      ld_data  = 1'b1;
                else if (i_req) ld_fetch = 1'b1;
            end
            IBUSY: begin
                if (acked) begin
                    if (d_req) ld_data   = 1'b1;
                    else       state_nxt = IDLE;
                end
            end
            DBUSY: begin
                if (acked) begin
                    if (i_req) ld_fetch  = 1'b1;
                    else       state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (ld_data)  state_nxt = DBUSY;
        if (ld_fetch) state_nxt = IBUSY;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_write <= 1'b0;
            m_size  <= SZ_WORD;
            m_addr  <= '0;
            m_wdata <= '0;
            bus_err <= 1'b0;
        end else begin
            if (ld_data) begin
                m_write <= d_write;
                m_size  <= d_size;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (ld_fetch) begin
                m_write <= 1'b0;
                m_size  <= SZ_WORD;
                m_addr  <= i_addr;
            end
            if (wd_inc && (wd_cnt == WDW'(TIMEOUT - 1))) begin
                bus_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNTW)) u_i_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (i_done),
        .cnt (i_grant_cnt)
    );

    sat_counter #(.W(CNTW)) u_d_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (d_done),
        .cnt (d_grant_cnt)
    );

    sat_counter #(.W(WDW)) u_watchdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .inc (wd_inc),
        .cnt (wd_cnt)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and random checks of mem_bus_arbiter against a transaction-level
// reference model of the arbitration, ack routing, counters and watchdog.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 12;
    localparam int unsigned CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_write, m_ack_n;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, m_rdata;
    logic [1:0]    d_size;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic          i_ack_n, d_ack_n, m_req, m_write, bus_err;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [CW-1:0] i_grant_cnt, d_grant_cnt;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CNTW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_ack_n     (i_ack_n),
        .d_req       (d_req),
        .d_write     (d_write),
        .d_size      (d_size),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ack_n     (d_ack_n),
        .m_req       (m_req),
        .m_write     (m_write),
        .m_size      (m_size),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ack_n     (m_ack_n),
        .bus_err     (bus_err),
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who currently owns the bus (0 none, 1 fetch, 2 data)
    int            owner;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [1:0]    e_size;
    logic          e_write;
    int            e_icnt, e_dcnt, e_wd;
    logic          e_err;
    bit            i_done, d_done;

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic grant_d();
        owner = 2; e_addr = d_addr; e_wdata = d_wdata; e_size = d_size; e_write = d_write;
    endtask

    task automatic grant_i();
        owner = 1; e_addr = i_addr; e_size = 2'b00; e_write = 1'b0;
    endtask

    task automatic model_edge();
        i_done = 0;
        d_done = 0;
        if (!rst) begin
            owner = 0; e_addr = '0; e_wdata = '0; e_size = 2'b00; e_write = 1'b0;
            e_icnt = 0; e_dcnt = 0; e_wd = 0; e_err = 1'b0;
        end else if (owner == 0) begin
            e_wd = 0;
            if (d_req)      grant_d();
            else if (i_req) grant_i();
        end else if (!m_ack_n) begin
            e_wd = 0;
            if (owner == 1) begin
                i_done = 1; e_icnt = sat_inc(e_icnt);
                if (d_req) grant_d(); else owner = 0;
            end else begin
                d_done = 1; e_dcnt = sat_inc(e_dcnt);
                if (i_req) grant_i(); else owner = 0;
            end
        end else begin
            if (e_wd < int'(TO)) e_wd++;
            if (e_wd == int'(TO)) e_err = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic exp_i, exp_d;
        exp_i = !(rst && owner == 1 && !m_ack_n);
        exp_d = !(rst && owner == 2 && !m_ack_n);
        check_eq("m_req",   64'(m_req),   64'(owner != 0));
        check_eq("m_addr",  64'(m_addr),  64'(e_addr));
        check_eq("m_write", 64'(m_write), 64'(e_write));
        check_eq("m_size",  64'(m_size),  64'(e_size));
        check_eq("m_wdata", 64'(m_wdata), 64'(e_wdata));
        check_eq("i_ack_n", 64'(i_ack_n), 64'(exp_i));
        check_eq("d_ack_n", 64'(d_ack_n), 64'(exp_d));
        if (!exp_i) check_eq("i_rdata", 64'(i_rdata), 64'(m_rdata));
        if (!exp_d) check_eq("d_rdata", 64'(d_rdata), 64'(m_rdata));
        check_eq("bus_err", 64'(bus_err), 64'(e_err));
        check_eq("i_cnt",   64'(i_grant_cnt), 64'(e_icnt));
        check_eq("d_cnt",   64'(d_grant_cnt), 64'(e_dcnt));
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ack_n = 1'b1;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] obs, exp_g;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; d_size = 2'b00;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);

        // Reset held with both requests pending, then data wins on release
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0000_2000; d_wdata = 32'h55;
        cycle();
        cycle();
        check_eq("rst_m_req", 64'(m_req), 64'd0);
        rst = 1'b1;
        cycle();
        check_eq("rst_rel_dbusy", 64'(m_req), 64'd1);
        check_eq("rst_rel_addr", 64'(m_addr), 64'h2000);
        m_ack_n = 1'b0;
        cycle();
        d_req = 1'b0;
        cycle();
        i_req = 1'b0; m_ack_n = 1'b1;
        cycle();

        // Single fetch with one wait cycle
        do_reset();
        i_req = 1'b1; i_addr = 32'h0001_0044;
        cycle();
        check_eq("fetch_addr", 64'(m_addr), 64'h0001_0044);
        check_eq("fetch_write", 64'(m_write), 64'd0);
        check_eq("fetch_size", 64'(m_size), 64'd0);
        cycle();
        m_ack_n = 1'b0; m_rdata = 32'h2402_0001;
        #1;
        check_eq("fetch_ack", 64'(i_ack_n), 64'd0);
        check_eq("fetch_rdata", 64'(i_rdata), 64'h2402_0001);
        cycle();
        i_req = 1'b0; m_ack_n = 1'b1;
        check_eq("fetch_cnt", 64'(i_grant_cnt), 64'd1);
        cycle();

        // Simultaneous: byte store first, fetch back-to-back
        do_reset();
        i_req = 1'b1; i_addr = 32'h0001_0048;
        d_req = 1'b1; d_write = 1'b1; d_size = 2'b10; d_addr = 32'hf000_0000; d_wdata = 32'h41;
        cycle();
        check_eq("st_write", 64'(m_write), 64'd1);
        check_eq("st_size", 64'(m_size), 64'h2);
        check_eq("st_wdata", 64'(m_wdata), 64'h41);
        check_eq("st_addr", 64'(m_addr), 64'hf000_0000);
        m_ack_n = 1'b0;
        cycle();
        d_req = 1'b0;
        check_eq("b2b_m_req", 64'(m_req), 64'd1);
        check_eq("b2b_addr", 64'(m_addr), 64'h0001_0048);
        check_eq("b2b_write", 64'(m_write), 64'd0);
        cycle();
        i_req = 1'b0; m_ack_n = 1'b1;
        cycle();

        // Continuous contention: D,I,D,I,...
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_write = 1'b0; d_size = 2'b01; d_addr = 32'h200;
        cycle();
        for (int k = 0; k < 10; k++) begin
            m_ack_n = 1'b0;
            m_rdata = $urandom;
            if (k == 9) d_req = 1'b0;
            #1;
            obs = !d_ack_n ? "D" : (!i_ack_n ? "I" : "-");
            exp_g = (k % 2 == 0) ? "D" : "I";
            check_eq($sformatf("alt_%0d", k), 64'(obs), 64'(exp_g));
            cycle();
        end
        i_req = 1'b0; d_req = 1'b0; m_ack_n = 1'b1;
        cycle();
        check_eq("alt_icnt", 64'(i_grant_cnt), 64'd5);
        check_eq("alt_dcnt", 64'(d_grant_cnt), 64'd5);

        // Watchdog: bus_err exactly after TO unacknowledged BUSY cycles
        do_reset();
        d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h300;
        cycle();
        for (int k = 0; k < int'(TO) - 1; k++) cycle();
        check_eq("wd_before", 64'(bus_err), 64'd0);
        cycle();
        check_eq("wd_at", 64'(bus_err), 64'd1);
        m_ack_n = 1'b0;
        cycle();
        d_req = 1'b0; m_ack_n = 1'b1;
        cycle();
        check_eq("wd_sticky", 64'(bus_err), 64'd1);
        check_eq("wd_done_cnt", 64'(d_grant_cnt), 64'd1);

        // Reset mid-DBUSY with ack present: no completion
        do_reset();
        d_req = 1'b1; d_addr = 32'h400;
        cycle();
        rst = 1'b0; m_ack_n = 1'b0;
        #1;
        check_eq("rstbusy_ack", 64'(d_ack_n), 64'd1);
        cycle();
        rst = 1'b1; d_req = 1'b0; m_ack_n = 1'b0;
        cycle();
        check_eq("rstbusy_cnt", 64'(d_grant_cnt), 64'd0);
        check_eq("rstbusy_mreq", 64'(m_req), 64'd0);
        m_ack_n = 1'b1;

        // Random traffic with occasional resets; counters saturate
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (!i_req || i_done) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = $urandom;
            end
            if (!d_req || d_done) begin
                d_req   = 1'($urandom_range(0, 1));
                d_write = 1'($urandom_range(0, 1));
                d_size  = 2'($urandom_range(0, 2));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            m_ack_n = ($urandom_range(0, 2) != 0);
            m_rdata = $urandom;
            rst     = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
